uart_boot_loader: RTL and testbench
===================================

# uart_boot_loader

Hardware boot loader that consumes received bytes from the memory-mapped UART peripheral's CPU-side register port and writes a framed program image into instruction memory. Instead of the CPU, it masters the UART's `addr`/`wdata`/`data`/`addr_strobe` interface, holding the CPU in reset until the image is loaded and verified. After a successful load it sends ACK; on a failed load it sends NAK.

## Interface
- `AddrWidth`, 32, memory address width (byte address).
- `BaseAddr`, 32'h0, byte address of the first loaded word.
- `MaxWords`, 4096, largest accepted word count.
- `Magic`, 8'hA5, frame start byte.
- `AckByte`, 8'h06, byte sent after a good load.
- `NakByte`, 8'h15, byte sent after a bad load.
- `clk  in  1`  system clock.
- `rst_n  in  1`  reset; asynchronous assert, active-low.
- `start  in  1`  pulse; begins a load when in IDLE, DONE or ERROR, ignored otherwise.
- `uart_addr  out  4`  UART register address.
- `uart_wdata  out  8`  UART write data.
- `uart_addr_strobe  out  1`  one-cycle access strobe.
- `uart_data  in  8`  UART read data, registered by the UART one cycle after the strobe.
- `mem_addr  out  AddrWidth`  word write address (byte address, 4-aligned).
- `mem_wdata  out  32`  word write data.
- `mem_we  out  1`  one-cycle write enable; memory always accepts.
- `cpu_rst_n  out  1`  CPU reset, low while not DONE.
- `busy  out  1`  load or response in progress.
- `done  out  1`  image loaded, checksum good.
- `error  out  1`  load failed.

## Operation
- UART registers used:
  - 0x0: rx ready, only bit 0 is valid.
  - 0x1: rx byte; it pops only when non-empty.
  - 0x3: tx byte.
  - 0x4: tx ready, only bit 0 is valid.
- Frame format, all multi-byte fields little-endian:
  - `Magic`.
  - Word count N, 2 bytes.
  - N×4 payload bytes.
  - Checksum byte, equal to the 8-bit modular sum of the payload bytes only.
- Byte fetch sequence:
  - RX_POLL: strobe addr 0x0.
  - RX_CHK: if `uart_data[0]` is 1, go to RX_READ; otherwise go back to RX_POLL.
  - RX_READ: strobe addr 0x1.
  - RX_CAP: capture `uart_data`, then dispatch on the current phase.
  - Address 0x1 is never strobed without a preceding ready=1.
- Phases:
  - HDR: a byte other than `Magic` is discarded and HDR continues (resync).
  - LEN_LO, LEN_HI: if N > `MaxWords`, go to the NAK response.
  - If N = 0, go straight to CSUM.
  - DATA: bytes are shifted into a 32-bit word, first byte to bits [7:0]. On the 4th byte, go to MEM_WR.
  - CSUM: match → ACK response; mismatch → NAK response.
- MEM_WR behaviour:
  - `mem_we`=1 for one cycle, with `mem_addr` = `BaseAddr` + 4·word_idx.
  - Then word_idx increments.
  - Then fetch continues in DATA, or moves to CSUM when word_idx = N.
- Response sequence:
  - TX_POLL: strobe 0x4.
  - TX_CHK: if `uart_data[0]` is 1, go to TX_SEND; otherwise go back to TX_POLL.
  - TX_SEND: strobe 0x3 with `uart_wdata` = ACK or NAK.
  - Then DONE (for ACK) or ERROR (for NAK).
- DONE: `done`=1, `cpu_rst_n`=1.
- ERROR: `error`=1, `cpu_rst_n`=0.
- `start` in DONE or ERROR clears `done`/`error`, drives `cpu_rst_n` low, and re-enters HDR.
- `busy`=1 in every state except IDLE, DONE and ERROR.
- A load that has no received bytes waits indefinitely; there is no timeout.

## Timing
- Reset values:
  - All outputs 0 (including `cpu_rst_n`).
  - State IDLE.
  - word_idx, checksum and shift register cleared.
- Reset mid-load: returns to IDLE immediately; memory contents are not restored.
- `uart_addr_strobe` is high for exactly one cycle per access and never on consecutive cycles.
- `uart_addr` and `uart_wdata` are valid in the strobe cycle.
- `uart_data` is sampled the cycle after the strobe.
- Byte cost: minimum 4 cycles (poll, check, read, capture); each extra poll round costs 2 cycles.
- `mem_we` fires the cycle after the 4th payload byte is captured.
- `start` to the first strobe is 1 cycle.
- TX_SEND to `done`/`error` high is 1 cycle.
- Width rules:
  - word_idx has width $clog2(MaxWords+1).
  - The address computation is truncated to `AddrWidth`.
  - The checksum wraps modulo 256.

## Structure
- Package `uart_boot_pkg` holds:
  - the state enum and the phase enum;
  - UART register address localparams (`UartRegRxReady`=4'h0, `UartRegRxData`=4'h1, `UartRegTxData`=4'h3, `UartRegTxReady`=4'h4).
- One sub-module, `uart_byte_port`, owns the poll/read/send handshake. Its interfaces:
  - Receive side: `rx_req`/`rx_valid`/`rx_byte`.
  - Transmit side: `tx_req`/`tx_byte`/`tx_done`.
- The top level holds the frame FSM, checksum and memory write.

## Test plan
- Frame A5,02,00,11,22,33,44,55,66,77,88,checksum 0x64:
  - Required writes: 0x44332211 @ `BaseAddr` and 0x88776655 @ `BaseAddr`+4.
  - 0x06 transmitted, then `done`=1 and `cpu_rst_n`=1.
- Same frame with checksum 0x65: both writes occur, 0x15 transmitted, `error`=1, `cpu_rst_n`=0.
- Leading junk 00,FF before A5,00,00,00: no writes, 0x06 sent, `done`=1.
- Length 0x1001 with `MaxWords`=4096: NAK sent right after LEN_HI, no payload reads, `error`=1.
- UART ready held 0 for 50 cycles mid-payload: only 0x0 is polled and 0x1 is never strobed; the load completes correctly afterwards.
- `rst_n` pulsed low after 2 words have been written: all outputs 0 and state IDLE; a subsequent `start` plus a full frame loads correctly.

Source files
------------

// File: rtl/uart_boot_pkg.sv
// -----------------------------------------------------------------------------
// uart_boot_pkg
// Shared types for the UART boot loader:
//   - boot_state_e : top-level frame FSM states
//   - phase_e      : which frame field the next received byte belongs to
//   - port_state_e : UART poll/read/send handshake states
//   - UART CPU-side register addresses
//   - csum_add     : 8-bit modular checksum accumulate
// -----------------------------------------------------------------------------
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_MEM_WR = 3'd2,
    ST_RESP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } boot_state_e;

  typedef enum logic [2:0] {
    PH_HDR    = 3'd0,
    PH_LEN_LO = 3'd1,
    PH_LEN_HI = 3'd2,
    PH_DATA   = 3'd3,
    PH_CSUM   = 3'd4
  } phase_e;

  typedef enum logic [2:0] {
    PS_IDLE    = 3'd0,
    PS_RX_POLL = 3'd1,
    PS_RX_CHK  = 3'd2,
    PS_RX_READ = 3'd3,
    PS_RX_CAP  = 3'd4,
    PS_TX_POLL = 3'd5,
    PS_TX_CHK  = 3'd6,
    PS_TX_SEND = 3'd7
  } port_state_e;

  localparam logic [3:0] UartRegRxReady = 4'h0;
  localparam logic [3:0] UartRegRxData  = 4'h1;
  localparam logic [3:0] UartRegTxData  = 4'h3;
  localparam logic [3:0] UartRegTxReady = 4'h4;

  // Checksum accumulate; the sum deliberately wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc_i, input logic [7:0] byte_i);
    csum_add = acc_i + byte_i;
  endfunction

endpackage

// File: rtl/uart_byte_port.sv
// -----------------------------------------------------------------------------
// uart_byte_port
// Drives the UART CPU-side register port on behalf of the boot loader.
//   Receive : rx_req_i asks for a byte; rx_valid_o pulses (with rx_byte_o) in
//             the capture cycle. The rx data register is only read after a
//             poll that returned ready=1.
//   Transmit: tx_req_i asks to send tx_byte_i; tx_done_o pulses in the cycle
//             the tx data register is written.
//   UART    : uart_addr_o / uart_wdata_o / uart_addr_strobe_o are registered;
//             uart_data_i is valid the cycle after a strobe.
// -----------------------------------------------------------------------------
module uart_byte_port
  import uart_boot_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_req_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  input  logic       tx_req_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_done_o,
  output logic [3:0] uart_addr_o,
  output logic [7:0] uart_wdata_o,
  output logic       uart_addr_strobe_o,
  input  logic [7:0] uart_data_i
);

  port_state_e state_q, state_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  // Handshake next-state. Requests are taken from idle and straight out of the
  // capture cycle so back-to-back bytes cost only four cycles each.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PS_IDLE, PS_RX_CAP: begin
        if (tx_req_i) begin
          state_d = PS_TX_POLL;
        end else if (rx_req_i) begin
          state_d = PS_RX_POLL;
        end else begin
          state_d = PS_IDLE;
        end
      end
      PS_RX_POLL: state_d = PS_RX_CHK;
      PS_RX_CHK: begin
        if (uart_data_i[0]) begin
          state_d = PS_RX_READ;
        end else begin
          state_d = PS_RX_POLL;
        end
      end
      PS_RX_READ: state_d = PS_RX_CAP;
      PS_TX_POLL: state_d = PS_TX_CHK;
      PS_TX_CHK: begin
        if (uart_data_i[0]) begin
          state_d = PS_TX_SEND;
        end else begin
          state_d = PS_TX_POLL;
        end
      end
      PS_TX_SEND: state_d = PS_IDLE;
      default:    state_d = PS_IDLE;
    endcase
  end

  // Bus controls are decoded from the next state so the registered strobe,
  // address and write data appear in the same cycle as the access state.
  always_comb begin
    strobe_d = 1'b0;
    addr_d   = 4'h0;
    wdata_d  = 8'h00;
    case (state_d)
      PS_RX_POLL: begin
        strobe_d = 1'b1;
        addr_d   = UartRegRxReady;
      end
      PS_RX_READ: begin
        strobe_d = 1'b1;
        addr_d   = UartRegRxData;
      end
      PS_TX_POLL: begin
        strobe_d = 1'b1;
        addr_d   = UartRegTxReady;
      end
      PS_TX_SEND: begin
        strobe_d = 1'b1;
        addr_d   = UartRegTxData;
        wdata_d  = tx_byte_i;
      end
      default: begin
        strobe_d = 1'b0;
        addr_d   = 4'h0;
        wdata_d  = 8'h00;
      end
    endcase
  end

  // Handshake state and registered UART bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= PS_IDLE;
      strobe_q <= 1'b0;
      addr_q   <= 4'h0;
      wdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rx_valid_o         = (state_q == PS_RX_CAP);
  assign rx_byte_o          = uart_data_i;
  assign tx_done_o          = (state_q == PS_TX_SEND);
  assign uart_addr_o        = addr_q;
  assign uart_wdata_o       = wdata_q;
  assign uart_addr_strobe_o = strobe_q;

endmodule

// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
// Receives a framed program image through the UART register port and writes
// it into instruction memory, holding the CPU in reset until the image has
// been loaded and its checksum verified. Replies ACK (good) or NAK (bad).
// Frame: Magic, N[7:0], N[15:8], N*4 payload bytes (LE words), checksum.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   start_i              : begin a load from IDLE/DONE/ERROR
//   uart_*               : UART CPU-side register port (this block is master)
//   mem_addr_o/wdata_o/we_o : instruction memory word write
//   cpu_rst_no           : CPU reset, released only in DONE
//   busy_o/done_o/error_o: status
// -----------------------------------------------------------------------------
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int                   AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(32'h0),
  parameter int                   MaxWords  = 4096,
  parameter logic [7:0]           Magic     = 8'hA5,
  parameter logic [7:0]           AckByte   = 8'h06,
  parameter logic [7:0]           NakByte   = 8'h15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic [3:0]           uart_addr_o,
  output logic [7:0]           uart_wdata_o,
  output logic                 uart_addr_strobe_o,
  input  logic [7:0]           uart_data_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic                 mem_we_o,
  output logic                 cpu_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int         IdxW      = $clog2(MaxWords + 1);
  localparam logic [31:0] MaxWordsU = 32'(MaxWords);

  boot_state_e          state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [IdxW-1:0]      word_cnt_q, word_cnt_d;
  logic [IdxW-1:0]      word_idx_q, word_idx_d;
  logic [IdxW-1:0]      idx_next_s;
  logic [7:0]           csum_q, csum_d;
  logic [31:0]          shift_q, shift_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic                 nak_q, nak_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, cpu_rst_n_q, busy_q, done_q, error_q;

  logic [15:0] len_s;
  logic        rx_req_s, rx_valid_s, tx_req_s, tx_done_s;
  logic [7:0]  rx_byte_s, tx_byte_s;

  // The byte port looks one cycle ahead: it is asked for a byte whenever the
  // frame FSM will be fetching next cycle, which gives the 1-cycle start to
  // strobe latency and lets fetches run back to back.
  assign rx_req_s   = (state_d == ST_FETCH);
  assign tx_req_s   = (state_d == ST_RESP);
  assign tx_byte_s  = nak_q ? NakByte : AckByte;
  assign len_s      = {rx_byte_s, len_lo_q};
  assign idx_next_s = word_idx_q + IdxW'(1'b1);

  uart_byte_port u_byte_port (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .rx_req_i           (rx_req_s),
    .rx_valid_o         (rx_valid_s),
    .rx_byte_o          (rx_byte_s),
    .tx_req_i           (tx_req_s),
    .tx_byte_i          (tx_byte_s),
    .tx_done_o          (tx_done_s),
    .uart_addr_o        (uart_addr_o),
    .uart_wdata_o       (uart_wdata_o),
    .uart_addr_strobe_o (uart_addr_strobe_o),
    .uart_data_i        (uart_data_i)
  );

  // Frame FSM next-state and datapath: header resync, length check, word
  // assembly, memory write sequencing and checksum verdict.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    len_lo_d    = len_lo_q;
    word_cnt_d  = word_cnt_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    nak_d       = nak_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d    = ST_FETCH;
          phase_d    = PH_HDR;
          word_idx_d = {IdxW{1'b0}};
          csum_d     = 8'h00;
          shift_d    = 32'h0000_0000;
          byte_cnt_d = 2'd0;
          nak_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        if (rx_valid_s) begin
          case (phase_q)
            PH_HDR: begin
              // Anything other than the start byte is dropped so a sender can
              // resynchronise by simply retransmitting the frame.
              if (rx_byte_s == Magic) begin
                phase_d = PH_LEN_LO;
              end else begin
                phase_d = PH_HDR;
              end
            end
            PH_LEN_LO: begin
              len_lo_d = rx_byte_s;
              phase_d  = PH_LEN_HI;
            end
            PH_LEN_HI: begin
              word_cnt_d = IdxW'(len_s);
              if ({16'h0000, len_s} > MaxWordsU) begin
                nak_d   = 1'b1;
                state_d = ST_RESP;
              end else if (len_s == 16'h0000) begin
                phase_d = PH_CSUM;
              end else begin
                phase_d = PH_DATA;
              end
            end
            PH_DATA: begin
              // Little-endian assembly: after four shifts the first byte
              // received sits in bits [7:0].
              shift_d    = {rx_byte_s, shift_q[31:8]};
              csum_d     = csum_add(csum_q, rx_byte_s);
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                state_d     = ST_MEM_WR;
                mem_wdata_d = {rx_byte_s, shift_q[31:8]};
                mem_addr_d  = BaseAddr + AddrWidth'({word_idx_q, 2'b00});
              end else begin
                state_d = ST_FETCH;
              end
            end
            PH_CSUM: begin
              nak_d   = (rx_byte_s != csum_q);
              state_d = ST_RESP;
            end
            default: phase_d = PH_HDR;
          endcase
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        word_idx_d = idx_next_s;
        state_d    = ST_FETCH;
        if (idx_next_s == word_cnt_q) begin
          phase_d = PH_CSUM;
        end else begin
          phase_d = PH_DATA;
        end
      end
      ST_RESP: begin
        if (tx_done_s) begin
          if (nak_q) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_HDR;
      len_lo_q    <= 8'h00;
      word_cnt_q  <= {IdxW{1'b0}};
      word_idx_q  <= {IdxW{1'b0}};
      csum_q      <= 8'h00;
      shift_q     <= 32'h0000_0000;
      byte_cnt_q  <= 2'd0;
      nak_q       <= 1'b0;
      mem_addr_q  <= {AddrWidth{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      len_lo_q    <= len_lo_d;
      word_cnt_q  <= word_cnt_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      nak_q       <= nak_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Status and write-enable outputs, registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_we_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q    <= (state_d == ST_MEM_WR);
      cpu_rst_n_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERROR);
      done_q      <= (state_d == ST_DONE);
      error_q     <= (state_d == ST_ERROR);
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign cpu_rst_no  = cpu_rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_boot_loader
// Drives uart_boot_loader with directed and randomised frames through a
// behavioural UART register model and compares memory writes, the response
// byte and status against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_boot_loader;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          MAXW  = 4096;
  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam logic [7:0]  ACK   = 8'h06;
  localparam logic [7:0]  NAK   = 8'h15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  uart_addr;
  logic [7:0]  uart_wdata;
  logic        uart_addr_strobe;
  logic [7:0]  uart_data = 8'h00;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .AddrWidth (32),
    .BaseAddr  (BASE),
    .MaxWords  (MAXW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .uart_addr_o        (uart_addr),
    .uart_wdata_o       (uart_wdata),
    .uart_addr_strobe_o (uart_addr_strobe),
    .uart_data_i        (uart_data),
    .mem_addr_o         (mem_addr),
    .mem_wdata_o        (mem_wdata),
    .mem_we_o           (mem_we),
    .cpu_rst_no         (cpu_rst_n),
    .busy_o             (busy),
    .done_o             (done),
    .error_o            (error)
  );

  // ---------------- UART and memory model ----------------
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        stall = 1'b0;
  logic        rand_stall = 1'b0;
  logic        rx_ready_nb = 1'b0;
  logic        tx_ready_nb = 1'b1;
  logic        last_rx_ready = 1'b0;
  logic        prev_strobe = 1'b0;
  int unsigned polls = 0, rd_strobes = 0, rd_no_ready = 0, back_to_back = 0;

  always @(negedge clk) begin
    rx_ready_nb <= (rx_q.size() > 0) && !stall && !(rand_stall && ($urandom_range(0, 2) == 0));
    tx_ready_nb <= ($urandom_range(0, 3) != 0);
  end

  always @(posedge clk) begin
    prev_strobe <= uart_addr_strobe;
    if (uart_addr_strobe) begin
      if (prev_strobe) back_to_back <= back_to_back + 1;
      case (uart_addr)
        4'h0: begin
          polls         <= polls + 1;
          last_rx_ready <= rx_ready_nb;
          uart_data     <= {7'd0, rx_ready_nb};
        end
        4'h1: begin
          rd_strobes <= rd_strobes + 1;
          if (!last_rx_ready) rd_no_ready <= rd_no_ready + 1;
          last_rx_ready <= 1'b0;
          if (rx_q.size() > 0) uart_data <= rx_q.pop_front();
          else uart_data <= 8'h00;
        end
        4'h3: tx_q.push_back(uart_wdata);
        4'h4: uart_data <= {7'd0, tx_ready_nb};
        default: uart_data <= 8'h00;
      endcase
    end
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  // ---------------- checking ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  frame_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_resp;
  int          exp_left;

  // Parse a frame the way the protocol defines it: skip to the first start
  // byte, read the length, collect words, compare the payload byte sum.
  task automatic model_frame();
    int i;
    int n;
    logic [7:0]  sum;
    logic [31:0] word;
    exp_addr_q.delete();
    exp_data_q.delete();
    i = 0;
    while (i < frame_q.size() && frame_q[i] != MAGIC) i++;
    i++;
    n = int'({frame_q[i+1], frame_q[i]});
    i += 2;
    if (n > MAXW) begin
      exp_resp = NAK;
    end else begin
      sum = 8'h00;
      for (int w = 0; w < n; w++) begin
        word = 32'h0;
        for (int b = 0; b < 4; b++) begin
          word[8*b +: 8] = frame_q[i];
          sum = sum + frame_q[i];
          i++;
        end
        exp_addr_q.push_back(BASE + 32'(4 * w));
        exp_data_q.push_back(word);
      end
      exp_resp = (frame_q[i] == sum) ? ACK : NAK;
      i++;
    end
    exp_left = frame_q.size() - i;
  endtask

  task automatic build_frame(input int n, input bit bad, input int junk);
    logic [7:0] b;
    logic [7:0] sum;
    frame_q.delete();
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == MAGIC) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(MAGIC);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    sum = 8'h00;
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom_range(0, 255));
      sum = sum + b;
      frame_q.push_back(b);
    end
    if (bad) sum = sum + 8'($urandom_range(1, 255));
    frame_q.push_back(sum);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load frame_q, optionally stalling the UART for 50 cycles once
  // stall_word words have been written, then compare everything.
  task automatic do_load(input string tag, input int stall_word);
    bit finished;
    bit stalled;
    int unsigned rd0, p0;
    model_frame();
    tx_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    foreach (frame_q[k]) rx_q.push_back(frame_q[k]);
    pulse_start();
    check_eq({tag, "_first_strobe"}, {59'd0, uart_addr_strobe, uart_addr}, {59'd0, 1'b1, 4'h0});
    finished = 1'b0;
    stalled  = 1'b0;
    for (int c = 0; c < 5000 && !finished; c++) begin
      if (stall_word >= 0 && !stalled && wr_data_q.size() == stall_word) begin
        stalled = 1'b1;
        stall   = 1'b1;
        repeat (4) @(negedge clk);
        rd0 = rd_strobes;
        p0  = polls;
        repeat (50) @(negedge clk);
        check_eq({tag, "_stall_reads"}, 64'(rd_strobes - rd0), 64'd0);
        check_eq({tag, "_stall_polls"}, 64'(polls > p0), 64'd1);
        check_eq({tag, "_stall_busy"}, 64'(busy), 64'd1);
        stall = 1'b0;
      end
      @(negedge clk);
      if (done || error) finished = 1'b1;
    end
    check_eq({tag, "_finished"}, 64'(finished), 64'd1);
    check_eq({tag, "_nwrites"}, 64'(wr_data_q.size()), 64'(exp_data_q.size()));
    for (int k = 0; k < exp_data_q.size(); k++) begin
      if (k < wr_data_q.size()) begin
        check_eq($sformatf("%s_waddr%0d", tag, k), 64'(wr_addr_q[k]), 64'(exp_addr_q[k]));
        check_eq($sformatf("%s_wdata%0d", tag, k), 64'(wr_data_q[k]), 64'(exp_data_q[k]));
      end
    end
    check_eq({tag, "_ntx"}, 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) check_eq({tag, "_txbyte"}, 64'(tx_q[0]), 64'(exp_resp));
    check_eq({tag, "_done"}, 64'(done), 64'(exp_resp == ACK));
    check_eq({tag, "_error"}, 64'(error), 64'(exp_resp == NAK));
    check_eq({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_resp == ACK));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_rx_left"}, 64'(rx_q.size()), 64'(exp_left));
    rx_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_uart"}, {51'd0, uart_addr_strobe, uart_addr, uart_wdata}, 64'd0);
    check_eq({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    check_eq({tag, "_status"}, {59'd0, mem_we, cpu_rst_n, busy, done, error}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit reached;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_no_strobe", 64'(uart_addr_strobe), 64'd0);

    // Reference frame with good checksum.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    do_load("good", -1);
    if (wr_data_q.size() == 2) begin
      check_eq("good_w0_const", 64'(wr_data_q[0]), 64'h44332211);
      check_eq("good_w1_const", 64'(wr_data_q[1]), 64'h88776655);
    end else begin
      check_eq("good_w_count_const", 64'(wr_data_q.size()), 64'd2);
    end

    // Same frame, checksum off by one.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    do_load("badsum", -1);

    // Leading junk, empty image.
    frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    do_load("junk", -1);

    // Oversized length; payload bytes behind it must stay unread.
    frame_q = '{8'hA5, 8'h01, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08};
    do_load("toolong", -1);

    // Stall mid-payload.
    build_frame(3, 1'b0, 0);
    do_load("stall", 1);

    // Exactly MaxWords is accepted: no NAK, loader keeps waiting for data.
    frame_q = '{8'hA5, 8'h00, 8'h10};
    tx_q.delete();
    foreach (frame_q[k]) rx_q.push_back(frame_q[k]);
    pulse_start();
    repeat (60) @(negedge clk);
    check_eq("maxw_no_tx", 64'(tx_q.size()), 64'd0);
    check_eq("maxw_busy", 64'(busy), 64'd1);
    check_eq("maxw_error", 64'(error), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    @(negedge clk);

    // Reset in the middle of a load.
    build_frame(4, 1'b0, 0);
    wr_data_q.delete();
    wr_addr_q.delete();
    foreach (frame_q[k]) rx_q.push_back(frame_q[k]);
    pulse_start();
    reached = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk);
      if (wr_data_q.size() == 2) reached = 1'b1;
    end
    check_eq("midrst_reached", 64'(reached), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    repeat (3) @(negedge clk);
    check_eq("midrst_idle_busy", 64'(busy), 64'd0);
    check_eq("midrst_idle_strobe", 64'(uart_addr_strobe), 64'd0);
    build_frame(3, 1'b0, 1);
    do_load("after_rst", -1);

    // Randomised frames with random UART back-pressure.
    for (int it = 0; it < 10; it++) begin
      rand_stall = 1'($urandom_range(0, 1));
      build_frame($urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      do_load($sformatf("rnd%0d", it), -1);
    end
    rand_stall = 1'b0;

    check_eq("rx_read_without_ready", 64'(rd_no_ready), 64'd0);
    check_eq("strobe_back_to_back", 64'(back_to_back), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
